// File: rtl/ctrl_addr_seq_if.sv
// Handshake bundle between the instruction source, the branch
// comparator and the control-ROM address sequencer.
interface ctrl_addr_seq_if #(
  parameter int WIDTH_ADD = 6
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instr;
  logic                 flush;
  logic                 cmp_valid;
  logic                 cmp_eq;
  logic                 cmp_lt;
  logic                 cmp_ltu;
  logic                 addr_valid;
  logic                 addr_ready;
  logic [WIDTH_ADD-1:0] rom_addr;
  logic                 illegal;

  modport master (
    output instr_valid, instr, flush,
    output cmp_valid, cmp_eq, cmp_lt, cmp_ltu,
    output addr_ready,
    input  instr_ready, addr_valid,
    input  rom_addr, illegal
  );

  modport slave (
    input  instr_valid, instr, flush,
    input  cmp_valid, cmp_eq, cmp_lt, cmp_ltu,
    input  addr_ready,
    output instr_ready, addr_valid,
    output rom_addr, illegal
  );
endinterface

// File: rtl/ctrl_addr_seq.sv
// RV32I decode to control-ROM address, with branch
// resolution against comparator flags and flush support.
module ctrl_addr_seq #(
  parameter int WIDTH_ADD = 6,
  parameter logic [WIDTH_ADD-1:0] ILLEGAL_ADDR = WIDTH_ADD'(63)
) (
  input logic         clk,
  input logic         rst_n,
  ctrl_addr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CMP = 2'd1,
    HOLD     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_EQ  = 2'd0,
    SEL_LT  = 2'd1,
    SEL_LTU = 2'd2
  } sel_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  localparam logic [WIDTH_ADD-1:0] ONE = WIDTH_ADD'(1);

  function automatic logic [WIDTH_ADD-1:0] A(
    input int unsigned n
  );
    return n[WIDTH_ADD-1:0];
  endfunction

  state_t               state;
  logic [WIDTH_ADD-1:0] br_base;
  sel_t                 br_sel;

  logic [WIDTH_ADD-1:0] dec_addr;
  logic                 dec_ill;
  logic                 dec_br;
  sel_t                 dec_sel;
  logic                 prim;
  logic                 accept;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7z;
  logic       f7a;

  assign op  = bus.instr[6:0];
  assign f3  = bus.instr[14:12];
  assign f7z = bus.instr[31:25] == 7'b0000000;
  assign f7a = bus.instr[31:25] == 7'b0100000;

  wire unused_ok = &{1'b0, bus.instr[24:15], bus.instr[11:7]};

  // Combinational decode of the presented instruction word.
  always_comb begin
    dec_addr = '0;
    dec_ill  = 1'b1;
    dec_br   = 1'b0;
    dec_sel  = SEL_EQ;
    if (bus.instr[1:0] == 2'b11) begin
      case (op)
        OP_R: begin
          case (f3)
            3'b000: begin
              dec_ill  = !(f7z || f7a);
              dec_addr = f7a ? A(1) : A(0);
            end
            3'b101: begin
              dec_ill  = !(f7z || f7a);
              dec_addr = f7a ? A(7) : A(6);
            end
            default: begin
              dec_ill = !f7z;
              case (f3)
                3'b001:  dec_addr = A(2);
                3'b010:  dec_addr = A(3);
                3'b011:  dec_addr = A(4);
                3'b100:  dec_addr = A(5);
                3'b110:  dec_addr = A(8);
                default: dec_addr = A(9);
              endcase
            end
          endcase
        end
        OP_I: begin
          dec_ill = 1'b0;
          case (f3)
            3'b000: dec_addr = A(10);
            3'b010: dec_addr = A(11);
            3'b011: dec_addr = A(12);
            3'b100: dec_addr = A(13);
            3'b110: dec_addr = A(14);
            3'b111: dec_addr = A(15);
            3'b001: begin
              dec_addr = A(16);
              dec_ill  = !f7z;
            end
            default: begin
              dec_addr = f7a ? A(18) : A(17);
              dec_ill  = !(f7z || f7a);
            end
          endcase
        end
        OP_LD: begin
          dec_ill = 1'b0;
          case (f3)
            3'b000:  dec_addr = A(19);
            3'b001:  dec_addr = A(20);
            3'b010:  dec_addr = A(21);
            3'b100:  dec_addr = A(22);
            3'b101:  dec_addr = A(23);
            default: dec_ill  = 1'b1;
          endcase
        end
        OP_ST: begin
          dec_ill = 1'b0;
          case (f3)
            3'b000:  dec_addr = A(24);
            3'b001:  dec_addr = A(25);
            3'b010:  dec_addr = A(26);
            default: dec_ill  = 1'b1;
          endcase
        end
        OP_BR: begin
          dec_ill = 1'b0;
          dec_br  = 1'b1;
          case (f3)
            3'b000: dec_addr = A(27);
            3'b001: dec_addr = A(29);
            3'b100: begin
              dec_addr = A(31);
              dec_sel  = SEL_LT;
            end
            3'b101: begin
              dec_addr = A(33);
              dec_sel  = SEL_LT;
            end
            3'b110: begin
              dec_addr = A(35);
              dec_sel  = SEL_LTU;
            end
            3'b111: begin
              dec_addr = A(37);
              dec_sel  = SEL_LTU;
            end
            default: begin
              dec_ill = 1'b1;
              dec_br  = 1'b0;
            end
          endcase
        end
        OP_LUI: begin
          dec_ill  = 1'b0;
          dec_addr = A(39);
        end
        OP_AUI: begin
          dec_ill  = 1'b0;
          dec_addr = A(40);
        end
        OP_JAL: begin
          dec_ill  = 1'b0;
          dec_addr = A(41);
        end
        OP_JR: begin
          dec_ill  = f3 != 3'b000;
          dec_addr = A(42);
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Select the comparator flag that picks the pair entry.
  always_comb begin
    prim = bus.cmp_ltu;
    unique case (br_sel)
      SEL_EQ:  prim = bus.cmp_eq;
      SEL_LT:  prim = bus.cmp_lt;
      default: prim = bus.cmp_ltu;
    endcase
  end

  assign bus.instr_ready = rst_n && !bus.flush &&
    (state == IDLE ||
     (state == HOLD && bus.addr_ready));

  assign accept = bus.instr_valid && bus.instr_ready;

  // Sequencer: accept, branch resolve, hold and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.addr_valid <= 1'b0;
      bus.rom_addr   <= '0;
      bus.illegal    <= 1'b0;
      br_base        <= '0;
      br_sel         <= SEL_EQ;
    end else if (bus.flush) begin
      state          <= IDLE;
      bus.addr_valid <= 1'b0;
    end else if (accept) begin
      if (dec_br && !dec_ill) begin
        state          <= WAIT_CMP;
        bus.addr_valid <= 1'b0;
        br_base        <= dec_addr;
        br_sel         <= dec_sel;
      end else begin
        state          <= HOLD;
        bus.addr_valid <= 1'b1;
        bus.rom_addr   <= dec_ill ? ILLEGAL_ADDR : dec_addr;
        bus.illegal    <= dec_ill;
      end
    end else begin
      case (state)
        WAIT_CMP: begin
          if (bus.cmp_valid) begin
            state          <= HOLD;
            bus.addr_valid <= 1'b1;
            bus.rom_addr   <= prim ? br_base : br_base + ONE;
            bus.illegal    <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.addr_ready) begin
            state          <= IDLE;
            bus.addr_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.addr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_addr_seq.sv
// Directed bench for ctrl_addr_seq: reset, streams,
// branches, backpressure, illegal decode and flush.
module tb_ctrl_addr_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  ctrl_addr_seq_if #(.WIDTH_ADD(6)) bus ();

  ctrl_addr_seq #(
    .WIDTH_ADD(6),
    .ILLEGAL_ADDR(6'd63)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.flush       = 1'b0;
    bus.cmp_valid   = 1'b0;
    bus.cmp_eq      = 1'b0;
    bus.cmp_lt      = 1'b0;
    bus.cmp_ltu     = 1'b0;
    bus.addr_ready  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({bus.addr_valid, bus.illegal, bus.rom_addr}
          !== 8'b0) begin
        fails++;
        $display("FAIL reset_out cyc%0d got v%b i%b a%0d want 0",
          i, bus.addr_valid, bus.illegal, bus.rom_addr);
      end
    end
    tests++;
    if (bus.instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdy got %b want 0",
        bus.instr_ready);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_rdy got %b want 1",
        bus.instr_ready);
    end
    tick();
    tests++;
    if ({bus.addr_valid, bus.illegal, bus.rom_addr}
        !== {2'b10, 6'd0}) begin
      fails++;
      $display("FAIL first_accept got v%b i%b a%0d want v1 i0 a0",
        bus.addr_valid, bus.illegal, bus.rom_addr);
    end
    bus.instr_valid = 1'b0;
    tick();
    tests++;
    if (bus.addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_idle got %b want 0",
        bus.addr_valid);
    end
  endtask

  task automatic test_rstream();
    logic [31:0] ins [3];
    logic [5:0]  exp [3];
    ins = '{32'h002081B3, 32'h402081B3, 32'h4020D193};
    exp = '{6'd0, 6'd1, 6'd18};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = ins[i];
      #1;
      tests++;
      if (bus.instr_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_rdy%0d got %b want 1",
          i, bus.instr_ready);
      end
      tick();
      tests++;
      if ({bus.addr_valid, bus.illegal, bus.rom_addr}
          !== {2'b10, exp[i]}) begin
        fails++;
        $display("FAIL stream%0d got v%b i%b a%0d want a%0d",
          i, bus.addr_valid, bus.illegal, bus.rom_addr,
          exp[i]);
      end
    end
    bus.instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_misc_decode();
    logic [31:0] ins [6];
    logic [5:0]  exp [6];
    ins = '{32'h000001B7, 32'h00000197, 32'h0000006F,
            32'h000080E7, 32'h00000023, 32'h0000F013};
    exp = '{6'd39, 6'd40, 6'd41, 6'd42, 6'd24, 6'd15};
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = ins[i];
      tick();
      tests++;
      if ({bus.addr_valid, bus.illegal, bus.rom_addr}
          !== {2'b10, exp[i]}) begin
        fails++;
        $display("FAIL misc%0d got v%b i%b a%0d want a%0d",
          i, bus.addr_valid, bus.illegal, bus.rom_addr,
          exp[i]);
      end
    end
    bus.instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    idle_inputs();
    bus.cmp_valid = 1'b1;
    bus.cmp_eq    = 1'b1;
    tick();
    tests++;
    if (bus.addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL cmp_idle got %b want 0",
        bus.addr_valid);
    end
    idle_inputs();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h00209463;
    tick();
    bus.instr = 32'h002081B3;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if ({bus.addr_valid, bus.instr_ready} !== 2'b00) begin
        fails++;
        $display("FAIL bne_wait%0d got v%b r%b want 0 0",
          i, bus.addr_valid, bus.instr_ready);
      end
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.cmp_valid   = 1'b1;
    bus.cmp_eq      = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.illegal, bus.rom_addr}
        !== {2'b10, 6'd29}) begin
      fails++;
      $display("FAIL bne got v%b i%b a%0d want a29",
        bus.addr_valid, bus.illegal, bus.rom_addr);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0020C463;
    tick();
    bus.instr_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.instr_ready} !== 2'b00) begin
      fails++;
      $display("FAIL blt_wait got v%b r%b want 0 0",
        bus.addr_valid, bus.instr_ready);
    end
    bus.cmp_valid = 1'b1;
    bus.cmp_eq    = 1'b1;
    bus.cmp_lt    = 1'b0;
    bus.cmp_ltu   = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.illegal, bus.rom_addr}
        !== {2'b10, 6'd32}) begin
      fails++;
      $display("FAIL blt got v%b i%b a%0d want a32",
        bus.addr_valid, bus.illegal, bus.rom_addr);
    end
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0000A103;
    tick();
    bus.addr_ready = 1'b0;
    bus.instr      = 32'h402081B3;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({bus.instr_ready, bus.addr_valid, bus.illegal,
           bus.rom_addr} !== {3'b010, 6'd21}) begin
        fails++;
        $display("FAIL bp%0d got r%b v%b i%b a%0d want a21",
          i, bus.instr_ready, bus.addr_valid, bus.illegal,
          bus.rom_addr);
      end
      tick();
    end
    bus.addr_ready = 1'b1;
    #1;
    tests++;
    if (bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_rdy got %b want 1",
        bus.instr_ready);
    end
    tick();
    bus.instr_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.rom_addr} !== {1'b1, 6'd1}) begin
      fails++;
      $display("FAIL bp_next got v%b a%0d want v1 a1",
        bus.addr_valid, bus.rom_addr);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [4];
    ins = '{32'hFFFFFFFF, 32'h0000B103,
            32'h402091B3, 32'h0000A063};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = ins[i];
      tick();
      tests++;
      if ({bus.addr_valid, bus.illegal, bus.rom_addr}
          !== {2'b11, 6'd63}) begin
        fails++;
        $display("FAIL ill%0d got v%b i%b a%0d want v1 i1 a63",
          i, bus.addr_valid, bus.illegal, bus.rom_addr);
      end
    end
    bus.instr = 32'h0060F063;
    tick();
    bus.instr_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.instr_ready} !== 2'b00) begin
      fails++;
      $display("FAIL bgeu_wait got v%b r%b want 0 0",
        bus.addr_valid, bus.instr_ready);
    end
    bus.cmp_valid = 1'b1;
    bus.cmp_ltu   = 1'b1;
    bus.cmp_lt    = 1'b0;
    bus.cmp_eq    = 1'b0;
    tick();
    bus.cmp_valid = 1'b0;
    tests++;
    if ({bus.addr_valid, bus.illegal, bus.rom_addr}
        !== {2'b10, 6'd37}) begin
      fails++;
      $display("FAIL bgeu got v%b i%b a%0d want v1 i0 a37",
        bus.addr_valid, bus.illegal, bus.rom_addr);
    end
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h00208063;
    tick();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    bus.flush       = 1'b1;
    bus.cmp_valid   = 1'b1;
    bus.cmp_eq      = 1'b1;
    #1;
    tests++;
    if (bus.instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_rdy got %b want 0",
        bus.instr_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if ({bus.addr_valid, bus.instr_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_wait got v%b r%b want v0 r1",
        bus.addr_valid, bus.instr_ready);
    end
    tick();
    tests++;
    if (bus.addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_disc got %b want 0",
        bus.addr_valid);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    tick();
    bus.instr = 32'h402081B3;
    bus.flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    tests++;
    if ({bus.addr_valid, bus.instr_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_hold got v%b r%b want v0 r1",
        bus.addr_valid, bus.instr_ready);
    end
    tick();
    tests++;
    if (bus.addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_noacc got %b want 0",
        bus.addr_valid);
    end
  endtask

  task automatic test_reset_midway();
    idle_inputs();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0000A103;
    tick();
    bus.instr_valid = 1'b0;
    rst_n           = 1'b0;
    tick();
    tests++;
    if ({bus.addr_valid, bus.illegal, bus.rom_addr}
        !== 8'b0) begin
      fails++;
      $display("FAIL rst_mid got v%b i%b a%0d want 0",
        bus.addr_valid, bus.illegal, bus.rom_addr);
    end
    rst_n = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h00209463;
    tick();
    bus.instr_valid = 1'b0;
    rst_n           = 1'b0;
    tick();
    rst_n         = 1'b1;
    bus.cmp_valid = 1'b1;
    bus.cmp_eq    = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    tests++;
    if (bus.addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_branch got %b want 0",
        bus.addr_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_rstream();
    test_misc_decode();
    test_branch();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_addr_seq.md
Name: ctrl_addr_seq

Overview:
- Decode/sequencing stage directly upstream of the 64-entry control ROM.
- Accepts a 32-bit RV32I instruction over a valid/ready handshake, decodes it to a 6-bit control-ROM address and presents that address with a valid/ready handshake.
- For conditional branches, it waits for the comparator flags and then selects the taken or not-taken entry of the ROM pair.
- Also flags illegal encodings and supports pipeline flush.

Parameters:
- WIDTH_ADD, 6: width of the ROM address output.
- ILLEGAL_ADDR, 6'd63: address driven when the instruction is illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  block accepts instr this cycle
- instr  in  32  instruction word
- flush  in  1  synchronous discard of in-flight instruction
- cmp_valid  in  1  comparator flags valid
- cmp_eq  in  1  rs1 == rs2
- cmp_lt  in  1  rs1 < rs2 (signed)
- cmp_ltu  in  1  rs1 < rs2 (unsigned)
- addr_valid  out  1  rom_addr valid
- addr_ready  in  1  ROM/control consumer takes address
- rom_addr  out  WIDTH_ADD  control-ROM address
- illegal  out  1  current address is for an illegal instruction (qualified by addr_valid)

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low.
- Reset values: state=IDLE, addr_valid=0, rom_addr=0, illegal=0. instr_ready is combinational and reads 1 once rst_n=1.
- States:
  - IDLE: no address pending.
  - WAIT_CMP: branch accepted, waiting for cmp_valid.
  - HOLD: addr_valid=1.
- instr_ready = !flush && (IDLE || (HOLD && addr_ready)). There is no skid buffer. Back-to-back throughput is one instruction per cycle for non-branches.
- On accept (instr_valid && instr_ready):
  - Branch: latch base address and primitive select, go to WAIT_CMP, addr_valid=0.
  - Otherwise: register rom_addr and illegal, go to HOLD next cycle. Latency is 1 cycle from accept to addr_valid.
- HOLD with addr_ready && !instr_valid: go to IDLE.
- HOLD with addr_ready && instr_valid: accept the new instruction in the same cycle.
- HOLD without addr_ready: rom_addr and illegal are held stable.
- WAIT_CMP with cmp_valid:
  - rom_addr = base + (prim ? 0 : 1).
  - prim is cmp_eq for BEQ/BNE, cmp_lt for BLT/BGE, cmp_ltu for BLTU/BGEU.
  - Next state is HOLD.
- cmp_valid outside WAIT_CMP is ignored.
- flush has priority over every event except reset:
  - Next state IDLE, addr_valid=0.
  - No instruction is accepted in a flush cycle, including when instr_valid is high.
  - flush in WAIT_CMP concurrent with cmp_valid discards the branch.
- Decode map (opcode, funct3, funct7[5]) -> address:
  - OP 0110011:
    - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
    - funct7 other than 0000000/0100000 is illegal.
    - 0100000 is legal only for ADD/SRL, giving SUB/SRA.
  - OP-IMM 0010011:
    - ADDI 10, SLTI 11, SLTIU 12, XORI 13, ORI 14, ANDI 15, SLLI 16, SRLI 17, SRAI 18.
    - Shift funct7 must be 0000000, or 0100000 for SRAI only.
  - LOAD 0000011:
    - LB 19, LH 20, LW 21, LBU 22, LHU 23.
    - funct3 011/110/111 are illegal.
  - STORE 0100011:
    - SB 24, SH 25, SW 26.
    - funct3 >= 011 is illegal.
  - BRANCH 1100011:
    - Base addresses: BEQ 27, BNE 29, BLT 31, BGE 33, BLTU 35, BGEU 37.
    - funct3 010/011 are illegal.
  - LUI 0110111 -> 39. AUIPC 0010111 -> 40. JAL 1101111 -> 41.
  - JALR 1100111 with funct3=000 -> 42.
  - Any other encoding is illegal.
- Illegal instruction handling:
  - rom_addr=ILLEGAL_ADDR, illegal=1, go to HOLD.
  - Never enters WAIT_CMP, even if the opcode is BRANCH.
- instr[1:0] != 2'b11 is illegal.
- Reset asserted in any state returns to the reset values on the next edge. Any pending branch or address is lost.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with instr_valid=1.
  - Required response: addr_valid=0, rom_addr=0, illegal=0. First accept occurs the cycle after rst_n=1.
- R/I stream:
  - Stimulus: send 0x002081B3 (ADD), 0x402081B3 (SUB), 0x4020D193 (SRAI) back-to-back with addr_ready=1.
  - Required response: rom_addr 0, 1, 18 on consecutive cycles, illegal=0, instr_ready constantly 1.
- Branch pair:
  - Stimulus 1: BNE 0x00209463, cmp_valid after 2 cycles with cmp_eq=1.
  - Required response 1: rom_addr=29.
  - Stimulus 2: BLT 0x0020C463 with cmp_lt=0.
  - Required response 2: rom_addr=32.
  - Throughout: addr_valid=0 and instr_ready=0 while in WAIT_CMP.
- Backpressure:
  - Stimulus: LW 0x0000A103 with addr_ready=0 for 4 cycles.
  - Required response: rom_addr=21 held stable, instr_ready=0. Release -> next instruction accepted in the same cycle.
- Illegal:
  - Stimulus: 0xFFFFFFFF, then 0x0000B103 (load funct3=011), then 0x0060F063 (branch funct3=111).
  - Required response:
    - First two: rom_addr=63, illegal=1.
    - Third is legal BGEU: WAIT_CMP, then cmp_ltu=1 -> rom_addr=37.
- Flush:
  - Stimulus: flush in WAIT_CMP coincident with cmp_valid, and again in HOLD with instr_valid=1.
  - Required response: addr_valid=0 next cycle, state IDLE, no instruction accepted during the flush cycle.
